// File: rtl/ds_sample_sequencer.sv
// Sample scheduler for the delta-sigma PW modulator: buffers host samples in a
// small FIFO and releases one every (pulses_per_sample+1) modulator pulses.
module ds_sample_sequencer #(
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned DEPTH_LOG2  = 2,
    parameter int unsigned DIV_BITS    = 8,
    parameter int unsigned PRIME_LEVEL = 2,
    parameter logic [SAMPLE_BITS-1:0] IDLE_VALUE = 16'h8000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   wr_valid,
    input  logic [SAMPLE_BITS-1:0] wr_data,
    output logic                   wr_ready,
    input  logic [DIV_BITS-1:0]    pulses_per_sample,
    input  logic                   pulse_done,
    output logic [SAMPLE_BITS-1:0] u_out,
    output logic                   sample_strobe,
    output logic [DEPTH_LOG2:0]    fifo_level,
    output logic                   underflow,
    input  logic                   underflow_clr,
    output logic [1:0]             state_out
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SAMPLE_BITS-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wptr;
    logic [DEPTH_LOG2-1:0]  r_rptr;
    logic [LW-1:0]          r_level;
    logic                   r_wr_ready;
    logic [DIV_BITS-1:0]    r_count;
    logic [SAMPLE_BITS-1:0] r_u;
    logic                   r_strobe;
    logic                   r_underflow;

    logic                   w_wr_acc;
    logic                   w_pop;
    logic [LW-1:0]          w_level_nxt;

    // Pop only from stored entries; a same-cycle write never bypasses to the head.
    always_comb begin
        w_wr_acc    = wr_valid && (r_level != LW'(DEPTH));
        w_pop       = 1'b0;
        if (enable && pulse_done) begin
            if (r_state == ST_PRIME)
                w_pop = (r_level >= LW'(PRIME_LEVEL));
            else if (r_state == ST_RUN)
                w_pop = (r_count == '0) && (r_level != '0);
        end
        w_level_nxt = flush ? '0 : (r_level + LW'(w_wr_acc) - LW'(w_pop));
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_wr_ready <= 1'b1;
        end else begin
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr_acc)
                    r_wptr <= r_wptr + DEPTH_LOG2'(1);
                if (w_pop)
                    r_rptr <= r_rptr + DEPTH_LOG2'(1);
            end
            r_level    <= w_level_nxt;
            r_wr_ready <= (w_level_nxt != LW'(DEPTH));
        end
    end

    // Sequencer FSM; disable wins over any pop and leaves the FIFO intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_u         <= IDLE_VALUE;
            r_strobe    <= 1'b0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (underflow_clr)
                r_underflow <= 1'b0;
            if (!enable) begin
                r_state <= ST_IDLE;
                r_u     <= IDLE_VALUE;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_PRIME;
                    ST_PRIME: begin
                        if (w_pop) begin
                            r_u      <= r_mem[r_rptr];
                            r_strobe <= 1'b1;
                            r_count  <= pulses_per_sample;
                            r_state  <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (pulse_done) begin
                            if (r_count != '0) begin
                                r_count <= r_count - DIV_BITS'(1);
                            end else if (w_pop) begin
                                r_u      <= r_mem[r_rptr];
                                r_strobe <= 1'b1;
                                r_count  <= pulses_per_sample;
                            end else begin
                                r_underflow <= 1'b1;
                                r_count     <= pulses_per_sample;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign wr_ready      = r_wr_ready;
    assign u_out         = r_u;
    assign sample_strobe = r_strobe;
    assign fifo_level    = r_level;
    assign underflow     = r_underflow;
    assign state_out     = r_state;

endmodule
